dl1_wbuf: RTL and testbench
===========================

# dl1_wbuf

Posted-write buffer between the DL1 data cache and the L2C. It sits directly downstream of DL1's L2C request port and presents the same request/response protocol on both sides. Writes are absorbed at zero wait state into a DEPTH-entry FIFO and drained to L2C in order. Reads are held until all older writes have drained and are then forwarded unmodified, which preserves ordering. Write TLB faults that occur during drain are reported to the control block through a sticky status register.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of 2, ≥2
- `AW`, default log2(DEPTH): pointer width
- `clk_mc` in 1: clock
- `rst_mc_n` in 1: reset, asynchronous, active-low
- `i_dl1_adr` in 32: request address; bits [1:0] are 0
- `i_dl1_flags` in 2: request flags; `2'b10` means cacheable
- `i_dl1_ben` in 4: byte enables
- `i_dl1_wen` in 1: 1 = write
- `i_dl1_wdata` in 32: write data
- `i_dl1_valid` in 1: request valid; held with payload until accepted
- `o_dl1_rdata` in/out 32 (out): read data, passed from `i_l2c_rdata`
- `o_dl1_rdata_valid` out 1: read beat valid
- `o_dl1_tlb_fault` out 1: read fault pulse
- `o_dl1_stall` out 1: request not accepted this cycle
- `o_l2c_adr` out 32, `o_l2c_flags` out 2, `o_l2c_ben` out 4, `o_l2c_wen` out 1, `o_l2c_wdata` out 32: downstream payload, registered
- `o_l2c_valid` out 1: downstream request valid, registered
- `i_l2c_rdata` in 32, `i_l2c_rdata_valid` in 1, `i_l2c_tlb_fault` in 1, `i_l2c_stall` in 1: L2C response
- `i_ctl_flush_req` in 1: drain request (level)
- `o_ctl_flush_ack` out 1: buffer empty and idle while flush is requested
- `o_ctl_wr_fault` out 1: sticky write-fault flag
- `o_ctl_wr_fault_adr` out 32: address of the first faulting write
- `i_ctl_fault_clr` in 1: clears the fault flag
- `o_ctl_occupancy` out AW+1: FIFO entry count

## Operation
- Handshake on both ports: a request is accepted in a cycle where valid=1 and stall=0. After acceptance the requester drops valid or presents the next request.
- FSM, one-hot: Idle, WrIssue, RdIssue.
- **Write push:** occurs when `i_dl1_valid & i_dl1_wen & ~full & ~i_ctl_flush_req & state!=RdIssue`. It stores {adr, flags, ben, wdata}, and `o_dl1_stall`=0 that cycle.
- **`o_dl1_stall`:**
  - 1 for a valid write when full, during flush, or in RdIssue.
  - 1 for a valid read unless the read completes this cycle.
  - 0 when `i_dl1_valid`=0 outside RdIssue.
- **Idle:**
  - FIFO non-empty: load the head into the `o_l2c_*` registers, set `o_l2c_valid`, go to WrIssue. Writes have priority.
  - Otherwise, a valid read (`i_dl1_valid & ~i_dl1_wen`) is captured into the `o_l2c_*` registers with valid=1, and the FSM goes to RdIssue.
- **WrIssue:**
  - Write done = `i_l2c_tlb_fault | ~i_l2c_stall`. On done, pop.
  - If the FIFO held ≥2 entries before the pop, load the next head and stay in WrIssue with valid held at 1 (back-to-back). Otherwise clear valid and go to Idle.
- **RdIssue:**
  - `o_l2c_valid` clears on the first cycle with `~i_l2c_stall`.
  - Read done = `i_l2c_tlb_fault`, or `~i_l2c_stall` with, for uncached flags, at least one `i_l2c_rdata_valid` seen so far (current cycle included).
  - On done go to Idle; `o_dl1_stall`=0 that cycle.
  - `o_dl1_rdata`/`o_dl1_rdata_valid`/`o_dl1_tlb_fault` are combinational pass-through in RdIssue, and 0 otherwise.
- **Write fault:**
  - A fault on a write done with `o_ctl_wr_fault`=0 sets the flag and latches `o_l2c_adr`. Later faults do not overwrite it.
  - Clear and a new fault in the same cycle: the fault wins.
- **Flush:** `o_ctl_flush_ack` = `i_ctl_flush_req & empty & Idle & ~o_l2c_valid`.
- **Full/empty:** counter-based. Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle leaves occupancy unchanged.
  - `full` is taken from the registered count, so a write that arrives while full is stalled even if a pop occurs that cycle.

## Timing
- Reset (async assert, sync-free release) sets:
  - state = Idle, pointers and count = 0, `o_l2c_valid`=0.
  - `o_l2c_adr`/`flags`/`ben`/`wen`/`wdata` = 0.
  - `o_ctl_wr_fault`=0, `o_ctl_wr_fault_adr`=0.
- Reset mid-operation discards queued writes. Combinational outputs are 0 while in reset.
- Write accepted in cycle N with an empty buffer: `o_l2c_valid` is 1 from cycle N+2.
- Read seen in Idle in cycle N with an empty FIFO: `o_l2c_valid` is 1 from cycle N+1.
- Read behind k queued writes: the read is not issued until the cycle after the last write completes.
- Back-to-back drain: one write issued per completion cycle, with no bubble.

## Test plan
- **Posted write then drain:** write adr `0x100`, data `0xDEADBEEF`, ben `0xF`, L2C stall=0 → stall=0 in the accept cycle; `o_l2c_valid` 2 cycles later with identical payload; occupancy goes 1→0.
- **Fill and overflow:** 5 writes with L2C stall held at 1 → first 4 accepted; 5th stalled while occupancy=4; drop L2C stall → drained in order, 5th accepted in the first cycle after count<4.
- **Read-after-write ordering:** 2 writes, then an uncached read at `0x200` → read `o_l2c_valid` appears only after both writes complete; one rdata beat `0x12345678` passed through; `o_dl1_stall` drops in the completion cycle.
- **Cacheable line read:** flags `2'b10`, 8 rdata beats, then L2C stall=0 → 8 pass-through beats; read completes on the cycle stall drops.
- **Write fault:** faults on writes 2 and 3 of 3 → flag=1 and fault_adr = write 2 address; asserting `i_ctl_fault_clr` in the same cycle as a fault leaves the flag at 1.
- **Flush and reset:** flush with 3 entries queued → new writes stalled; ack rises after the last write completes. Assert `rst_mc_n`=0 mid-drain → occupancy 0, `o_l2c_valid`=0 immediately.

Source files
------------

// File: rtl/dl1_wbuf.sv
// Posted-write buffer between the DL1 request port and the L2C. Writes are queued and
// drained in order. A read waits until the queue is empty and is then forwarded as-is.
module dl1_wbuf #(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_mc,
   input  logic          rst_mc_n,
   input  logic [31:0]   i_dl1_adr,
   input  logic [1:0]    i_dl1_flags,
   input  logic [3:0]    i_dl1_ben,
   input  logic          i_dl1_wen,
   input  logic [31:0]   i_dl1_wdata,
   input  logic          i_dl1_valid,
   output logic [31:0]   o_dl1_rdata,
   output logic          o_dl1_rdata_valid,
   output logic          o_dl1_tlb_fault,
   output logic          o_dl1_stall,
   output logic [31:0]   o_l2c_adr,
   output logic [1:0]    o_l2c_flags,
   output logic [3:0]    o_l2c_ben,
   output logic          o_l2c_wen,
   output logic [31:0]   o_l2c_wdata,
   output logic          o_l2c_valid,
   input  logic [31:0]   i_l2c_rdata,
   input  logic          i_l2c_rdata_valid,
   input  logic          i_l2c_tlb_fault,
   input  logic          i_l2c_stall,
   input  logic          i_ctl_flush_req,
   output logic          o_ctl_flush_ack,
   output logic          o_ctl_wr_fault,
   output logic [31:0]   o_ctl_wr_fault_adr,
   input  logic          i_ctl_fault_clr,
   output logic [AW:0]   o_ctl_occupancy
);

   typedef enum logic [2:0] {
      IDLE     = 3'b001,
      WR_ISSUE = 3'b010,
      RD_ISSUE = 3'b100
   } state_t;

   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   state_t        state;
   logic [31:0]   fifo_adr   [DEPTH];
   logic [1:0]    fifo_flags [DEPTH];
   logic [3:0]    fifo_ben   [DEPTH];
   logic [31:0]   fifo_wdata [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] next_ptr;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          is_idle;
   logic          is_wr;
   logic          is_rd;
   logic          push;
   logic          pop;
   logic          wr_done;
   logic          rd_done;
   logic          rd_beat_seen;
   logic          rd_cacheable;
   logic          more_queued;

   // DEPTH is a power of two, so the count reaches DEPTH exactly when its top bit sets.
   assign full        = count[AW];
   assign empty       = (count == '0);
   assign more_queued = (count > CNT_ONE);
   assign next_ptr    = rd_ptr + PTR_ONE;

   assign is_idle = (state == IDLE);
   assign is_wr   = (state == WR_ISSUE);
   assign is_rd   = (state == RD_ISSUE);

   assign rd_cacheable = (o_l2c_flags == 2'b10);
   assign push    = i_dl1_valid & i_dl1_wen & ~full & ~i_ctl_flush_req & ~is_rd;
   assign wr_done = is_wr & (i_l2c_tlb_fault | ~i_l2c_stall);
   assign pop     = wr_done;
   // An uncached read must have seen its data beat before the L2C may release it.
   assign rd_done = is_rd & (i_l2c_tlb_fault |
                    (~i_l2c_stall & (rd_cacheable | rd_beat_seen | i_l2c_rdata_valid)));

   assign o_dl1_rdata       = is_rd ? i_l2c_rdata : '0;
   assign o_dl1_rdata_valid = is_rd & i_l2c_rdata_valid;
   assign o_dl1_tlb_fault   = is_rd & i_l2c_tlb_fault;
   assign o_ctl_flush_ack   = rst_mc_n & i_ctl_flush_req & empty & is_idle & ~o_l2c_valid;
   assign o_ctl_occupancy   = count;

   always_comb begin
      o_dl1_stall = 1'b0;
      if (rst_mc_n) begin
         if (i_dl1_valid & i_dl1_wen) begin
            o_dl1_stall = ~push;
         end else if (i_dl1_valid) begin
            o_dl1_stall = ~rd_done;
         end else begin
            o_dl1_stall = is_rd & ~rd_done;
         end
      end
   end

   always_ff @(posedge clk_mc) begin
      if (push) begin
         fifo_adr[wr_ptr]   <= i_dl1_adr;
         fifo_flags[wr_ptr] <= i_dl1_flags;
         fifo_ben[wr_ptr]   <= i_dl1_ben;
         fifo_wdata[wr_ptr] <= i_dl1_wdata;
      end
   end

   always_ff @(posedge clk_mc or negedge rst_mc_n) begin
      if (!rst_mc_n) begin
         state              <= IDLE;
         wr_ptr             <= '0;
         rd_ptr             <= '0;
         count              <= '0;
         rd_beat_seen       <= 1'b0;
         o_l2c_adr          <= '0;
         o_l2c_flags        <= '0;
         o_l2c_ben          <= '0;
         o_l2c_wen          <= 1'b0;
         o_l2c_wdata        <= '0;
         o_l2c_valid        <= 1'b0;
         o_ctl_wr_fault     <= 1'b0;
         o_ctl_wr_fault_adr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= next_ptr;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase

         // Only the first fault is recorded; a fault beats a simultaneous clear.
         if (wr_done & i_l2c_tlb_fault) begin
            if (!o_ctl_wr_fault) o_ctl_wr_fault_adr <= o_l2c_adr;
            o_ctl_wr_fault <= 1'b1;
         end else if (i_ctl_fault_clr) begin
            o_ctl_wr_fault <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!empty) begin
                  o_l2c_adr   <= fifo_adr[rd_ptr];
                  o_l2c_flags <= fifo_flags[rd_ptr];
                  o_l2c_ben   <= fifo_ben[rd_ptr];
                  o_l2c_wdata <= fifo_wdata[rd_ptr];
                  o_l2c_wen   <= 1'b1;
                  o_l2c_valid <= 1'b1;
                  state       <= WR_ISSUE;
               end else if (i_dl1_valid & ~i_dl1_wen) begin
                  o_l2c_adr    <= i_dl1_adr;
                  o_l2c_flags  <= i_dl1_flags;
                  o_l2c_ben    <= i_dl1_ben;
                  o_l2c_wdata  <= i_dl1_wdata;
                  o_l2c_wen    <= 1'b0;
                  o_l2c_valid  <= 1'b1;
                  rd_beat_seen <= 1'b0;
                  state        <= RD_ISSUE;
               end
            end
            WR_ISSUE: begin
               if (wr_done) begin
                  if (more_queued) begin
                     o_l2c_adr   <= fifo_adr[next_ptr];
                     o_l2c_flags <= fifo_flags[next_ptr];
                     o_l2c_ben   <= fifo_ben[next_ptr];
                     o_l2c_wdata <= fifo_wdata[next_ptr];
                  end else begin
                     o_l2c_valid <= 1'b0;
                     state       <= IDLE;
                  end
               end
            end
            RD_ISSUE: begin
               if (i_l2c_rdata_valid) rd_beat_seen <= 1'b1;
               if (!i_l2c_stall) o_l2c_valid <= 1'b0;
               if (rd_done) begin
                  o_l2c_valid <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               o_l2c_valid <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dl1_wbuf.sv
// Testbench for dl1_wbuf: transaction-level scoreboard checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_dl1_wbuf;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   logic          clk_mc;
   logic          rst_mc_n;
   logic [31:0]   i_dl1_adr;
   logic [1:0]    i_dl1_flags;
   logic [3:0]    i_dl1_ben;
   logic          i_dl1_wen;
   logic [31:0]   i_dl1_wdata;
   logic          i_dl1_valid;
   logic [31:0]   o_dl1_rdata;
   logic          o_dl1_rdata_valid;
   logic          o_dl1_tlb_fault;
   logic          o_dl1_stall;
   logic [31:0]   o_l2c_adr;
   logic [1:0]    o_l2c_flags;
   logic [3:0]    o_l2c_ben;
   logic          o_l2c_wen;
   logic [31:0]   o_l2c_wdata;
   logic          o_l2c_valid;
   logic [31:0]   i_l2c_rdata;
   logic          i_l2c_rdata_valid;
   logic          i_l2c_tlb_fault;
   logic          i_l2c_stall;
   logic          i_ctl_flush_req;
   logic          o_ctl_flush_ack;
   logic          o_ctl_wr_fault;
   logic [31:0]   o_ctl_wr_fault_adr;
   logic          i_ctl_fault_clr;
   logic [AW:0]   o_ctl_occupancy;

   dl1_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_mc             (clk_mc),
      .rst_mc_n           (rst_mc_n),
      .i_dl1_adr          (i_dl1_adr),
      .i_dl1_flags        (i_dl1_flags),
      .i_dl1_ben          (i_dl1_ben),
      .i_dl1_wen          (i_dl1_wen),
      .i_dl1_wdata        (i_dl1_wdata),
      .i_dl1_valid        (i_dl1_valid),
      .o_dl1_rdata        (o_dl1_rdata),
      .o_dl1_rdata_valid  (o_dl1_rdata_valid),
      .o_dl1_tlb_fault    (o_dl1_tlb_fault),
      .o_dl1_stall        (o_dl1_stall),
      .o_l2c_adr          (o_l2c_adr),
      .o_l2c_flags        (o_l2c_flags),
      .o_l2c_ben          (o_l2c_ben),
      .o_l2c_wen          (o_l2c_wen),
      .o_l2c_wdata        (o_l2c_wdata),
      .o_l2c_valid        (o_l2c_valid),
      .i_l2c_rdata        (i_l2c_rdata),
      .i_l2c_rdata_valid  (i_l2c_rdata_valid),
      .i_l2c_tlb_fault    (i_l2c_tlb_fault),
      .i_l2c_stall        (i_l2c_stall),
      .i_ctl_flush_req    (i_ctl_flush_req),
      .o_ctl_flush_ack    (o_ctl_flush_ack),
      .o_ctl_wr_fault     (o_ctl_wr_fault),
      .o_ctl_wr_fault_adr (o_ctl_wr_fault_adr),
      .i_ctl_fault_clr    (i_ctl_fault_clr),
      .o_ctl_occupancy    (o_ctl_occupancy)
   );

   initial clk_mc = 1'b0;
   always #5 clk_mc = ~clk_mc;

   int nChecks = 0;
   int nFails  = 0;

   task automatic checkOutput(input string name, input logic [69:0] actual, input logic [69:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Model: queue of posted writes {adr, flags, ben, wdata}, sticky fault, read-in-flight.
   logic [69:0] wq[$];
   int          mCount    = 0;
   bit          mFault    = 1'b0;
   logic [31:0] mFaultAdr = '0;
   bit          rdActive  = 1'b0;
   bit          rdBeat    = 1'b0;
   bit          wrReq, rdReq, rdDone, expStall, expAck, wrComplete;

   always @(negedge clk_mc) begin
      if (!rst_mc_n) begin
         checkOutput("rst_stall", o_dl1_stall, 0);
         checkOutput("rst_l2c_valid", o_l2c_valid, 0);
         checkOutput("rst_occupancy", o_ctl_occupancy, 0);
         checkOutput("rst_l2c_adr_data", {o_l2c_adr, o_l2c_wdata}, 0);
         checkOutput("rst_l2c_ctl", {o_l2c_flags, o_l2c_ben, o_l2c_wen}, 0);
         checkOutput("rst_wr_fault", {o_ctl_wr_fault, o_ctl_wr_fault_adr}, 0);
         checkOutput("rst_rdata_valid", o_dl1_rdata_valid, 0);
         wq.delete();
         mCount    = 0;
         mFault    = 1'b0;
         mFaultAdr = '0;
         rdActive  = 1'b0;
         rdBeat    = 1'b0;
      end else begin
         wrReq = i_dl1_valid & i_dl1_wen;
         rdReq = i_dl1_valid & ~i_dl1_wen;
         if (o_l2c_valid && !o_l2c_wen && !rdActive) begin
            rdActive = 1'b1;
            rdBeat   = 1'b0;
            checkOutput("rd_after_writes", mCount, 0);
            checkOutput("rd_payload", {o_l2c_adr, o_l2c_flags, o_l2c_ben}, {i_dl1_adr, i_dl1_flags, i_dl1_ben});
         end
         rdDone = rdActive & (i_l2c_tlb_fault |
                  (~i_l2c_stall & ((i_dl1_flags == 2'b10) | rdBeat | i_l2c_rdata_valid)));
         if (wrReq)      expStall = (mCount == DEPTH) | i_ctl_flush_req | rdActive;
         else if (rdReq) expStall = ~rdDone;
         else            expStall = rdActive & ~rdDone;
         expAck = i_ctl_flush_req & (mCount == 0) & ~rdActive & ~o_l2c_valid;

         checkOutput("occupancy", o_ctl_occupancy, mCount);
         checkOutput("dl1_stall", o_dl1_stall, expStall);
         checkOutput("flush_ack", o_ctl_flush_ack, expAck);
         checkOutput("wr_fault_flag", o_ctl_wr_fault, mFault);
         checkOutput("wr_fault_adr", o_ctl_wr_fault_adr, mFaultAdr);
         checkOutput("rd_pass", {o_dl1_rdata_valid, o_dl1_tlb_fault, o_dl1_rdata},
                     rdActive ? {i_l2c_rdata_valid, i_l2c_tlb_fault, i_l2c_rdata} : 34'd0);

         wrComplete = o_l2c_valid & o_l2c_wen & (i_l2c_tlb_fault | ~i_l2c_stall);
         if (wrComplete) begin
            if (wq.size() == 0) begin
               checkOutput("wr_spurious", 1, 0);
            end else begin
               checkOutput("wr_payload", {o_l2c_adr, o_l2c_flags, o_l2c_ben, o_l2c_wdata}, wq[0]);
               if (i_l2c_tlb_fault) begin
                  if (!mFault) mFaultAdr = wq[0][69:38];
                  mFault = 1'b1;
               end else if (i_ctl_fault_clr) begin
                  mFault = 1'b0;
               end
               void'(wq.pop_front());
               mCount--;
            end
         end else if (i_ctl_fault_clr) begin
            mFault = 1'b0;
         end
         if (wrReq && !expStall) begin
            wq.push_back({i_dl1_adr, i_dl1_flags, i_dl1_ben, i_dl1_wdata});
            mCount++;
         end
         if (rdActive) begin
            if (i_l2c_rdata_valid) rdBeat = 1'b1;
            if (rdDone) rdActive = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk_mc);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic wen, input logic [31:0] adr,
                                input logic [1:0] flags, input logic [3:0] ben, input logic [31:0] wdata);
      i_dl1_valid = valid;
      i_dl1_wen   = wen;
      i_dl1_adr   = adr;
      i_dl1_flags = flags;
      i_dl1_ben   = ben;
      i_dl1_wdata = wdata;
   endtask

   task automatic doWrite(input logic [31:0] adr, input logic [31:0] wdata);
      int n = 0;
      applyStimulus(1'b1, 1'b1, adr, 2'b00, 4'hF, wdata);
      @(negedge clk_mc);
      while (o_dl1_stall && n < 40) begin
         tick();
         @(negedge clk_mc);
         n++;
      end
      checkOutput("write_accept_bound", o_dl1_stall, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 4'h0, 32'h0);
   endtask

   task automatic waitL2c(input string name, input logic wen);
      int n = 0;
      @(negedge clk_mc);
      while (!(o_l2c_valid && o_l2c_wen == wen) && n < 40) begin
         tick();
         @(negedge clk_mc);
         n++;
      end
      checkOutput(name, {o_l2c_valid, o_l2c_wen}, {1'b1, wen});
   endtask

   task automatic waitDrained(input string name);
      int n = 0;
      @(negedge clk_mc);
      while ((o_ctl_occupancy != 0 || o_l2c_valid) && n < 40) begin
         tick();
         @(negedge clk_mc);
         n++;
      end
      checkOutput(name, {o_ctl_occupancy, o_l2c_valid}, 0);
   endtask

   initial begin
      #50000;
      nFails++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      logic [31:0] beat;
      int n;
      rst_mc_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 4'h0, 32'h0);
      i_l2c_rdata = '0; i_l2c_rdata_valid = 1'b0; i_l2c_tlb_fault = 1'b0; i_l2c_stall = 1'b0;
      i_ctl_flush_req = 1'b0; i_ctl_fault_clr = 1'b0;
      #2 rst_mc_n = 1'b0;
      repeat (3) tick();
      rst_mc_n = 1'b1;
      tick();

      $display("[TB] posted write then drain");
      applyStimulus(1'b1, 1'b1, 32'h100, 2'b00, 4'hF, 32'hDEADBEEF);
      @(negedge clk_mc);
      checkOutput("t1_accept_stall", o_dl1_stall, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 4'h0, 32'h0);
      @(negedge clk_mc);
      checkOutput("t1_occ_n1", o_ctl_occupancy, 1);
      checkOutput("t1_valid_n1", o_l2c_valid, 0);
      tick();
      @(negedge clk_mc);
      checkOutput("t1_valid_n2", o_l2c_valid, 1);
      checkOutput("t1_payload", {o_l2c_adr, o_l2c_wdata, o_l2c_ben, o_l2c_wen}, {32'h100, 32'hDEADBEEF, 4'hF, 1'b1});
      tick();
      @(negedge clk_mc);
      checkOutput("t1_occ_n3", o_ctl_occupancy, 0);
      checkOutput("t1_valid_n3", o_l2c_valid, 0);
      tick();

      $display("[TB] fill and overflow");
      i_l2c_stall = 1'b1;
      for (int i = 0; i < 4; i++) doWrite(32'h500 + 32'(i * 4), 32'h11110000 + 32'(i));
      applyStimulus(1'b1, 1'b1, 32'h510, 2'b00, 4'hF, 32'h11110004);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_mc);
         checkOutput("t2_full_stall", o_dl1_stall, 1);
         checkOutput("t2_full_occ", o_ctl_occupancy, 4);
         tick();
      end
      i_l2c_stall = 1'b0;
      @(negedge clk_mc);
      checkOutput("t2_pop_cycle_stall", o_dl1_stall, 1);
      tick();
      @(negedge clk_mc);
      checkOutput("t2_fifth_accept", o_dl1_stall, 0);
      checkOutput("t2_occ_after_pop", o_ctl_occupancy, 3);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 4'h0, 32'h0);
      waitDrained("t2_drained");
      tick();

      $display("[TB] read after write ordering");
      doWrite(32'h600, 32'hA5A50001);
      doWrite(32'h604, 32'hA5A50002);
      applyStimulus(1'b1, 1'b0, 32'h200, 2'b00, 4'hF, 32'h0);
      waitL2c("t3_read_issued", 1'b0);
      checkOutput("t3_occ_at_issue", o_ctl_occupancy, 0);
      checkOutput("t3_read_adr", o_l2c_adr, 32'h200);
      checkOutput("t3_stall_before_beat", o_dl1_stall, 1);
      tick();
      i_l2c_rdata = 32'h12345678; i_l2c_rdata_valid = 1'b1;
      @(negedge clk_mc);
      checkOutput("t3_beat", {o_dl1_rdata_valid, o_dl1_rdata}, {1'b1, 32'h12345678});
      checkOutput("t3_done_stall", o_dl1_stall, 0);
      tick();
      i_l2c_rdata = '0; i_l2c_rdata_valid = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 4'h0, 32'h0);
      tick();

      $display("[TB] cacheable line read");
      i_l2c_stall = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h300, 2'b10, 4'hF, 32'h0);
      waitL2c("t4_read_issued", 1'b0);
      for (int i = 0; i < 8; i++) begin
         tick();
         beat = 32'hC0DE0000 + 32'(i);
         i_l2c_rdata = beat; i_l2c_rdata_valid = 1'b1;
         @(negedge clk_mc);
         checkOutput("t4_beat", {o_dl1_rdata_valid, o_dl1_rdata}, {1'b1, beat});
         checkOutput("t4_beat_stall", o_dl1_stall, 1);
      end
      tick();
      i_l2c_rdata = '0; i_l2c_rdata_valid = 1'b0; i_l2c_stall = 1'b0;
      @(negedge clk_mc);
      checkOutput("t4_done_stall", o_dl1_stall, 0);
      tick();
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 4'h0, 32'h0);
      tick();

      $display("[TB] write fault");
      i_l2c_stall = 1'b1;
      doWrite(32'h400, 32'hF0000001);
      doWrite(32'h404, 32'hF0000002);
      doWrite(32'h408, 32'hF0000003);
      waitL2c("t5_write_issued", 1'b1);
      tick();
      i_l2c_stall = 1'b0;
      tick();
      i_l2c_tlb_fault = 1'b1;
      tick();
      i_ctl_fault_clr = 1'b1;
      tick();
      i_l2c_tlb_fault = 1'b0; i_ctl_fault_clr = 1'b0;
      @(negedge clk_mc);
      checkOutput("t5_fault_flag", o_ctl_wr_fault, 1);
      checkOutput("t5_fault_adr", o_ctl_wr_fault_adr, 32'h404);
      checkOutput("t5_occ", o_ctl_occupancy, 0);
      tick();
      i_ctl_fault_clr = 1'b1;
      tick();
      i_ctl_fault_clr = 1'b0;
      @(negedge clk_mc);
      checkOutput("t5_fault_cleared", o_ctl_wr_fault, 0);
      tick();

      $display("[TB] flush and reset");
      i_l2c_stall = 1'b1;
      doWrite(32'h700, 32'h77770000);
      doWrite(32'h704, 32'h77770001);
      doWrite(32'h708, 32'h77770002);
      i_ctl_flush_req = 1'b1;
      applyStimulus(1'b1, 1'b1, 32'h7F0, 2'b00, 4'hF, 32'h7777FFFF);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_mc);
         checkOutput("t6_flush_stall", o_dl1_stall, 1);
         checkOutput("t6_flush_ack_busy", o_ctl_flush_ack, 0);
         tick();
      end
      applyStimulus(1'b0, 1'b0, 32'h0, 2'b00, 4'h0, 32'h0);
      i_l2c_stall = 1'b0;
      n = 0;
      @(negedge clk_mc);
      while (!o_ctl_flush_ack && n < 20) begin
         tick();
         @(negedge clk_mc);
         n++;
      end
      checkOutput("t6_flush_ack", o_ctl_flush_ack, 1);
      checkOutput("t6_flush_occ", o_ctl_occupancy, 0);
      tick();
      i_ctl_flush_req = 1'b0;

      i_l2c_stall = 1'b1;
      doWrite(32'h800, 32'h88880000);
      doWrite(32'h804, 32'h88880001);
      doWrite(32'h808, 32'h88880002);
      i_l2c_stall = 1'b0;
      tick();
      rst_mc_n = 1'b0;
      #1;
      checkOutput("t6_reset_occ", o_ctl_occupancy, 0);
      checkOutput("t6_reset_valid", o_l2c_valid, 0);
      repeat (2) tick();
      rst_mc_n = 1'b1;
      repeat (3) tick();
      @(negedge clk_mc);
      checkOutput("t6_post_reset_idle", {o_ctl_occupancy, o_l2c_valid}, 0);
      tick();

      checkOutput("final_queue_empty", wq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
